// File: rtl/bu_writeback_router.sv
// Write-back router for the 8-BU NTT datapath.
// Delays the per-beat control (valid, len, mode, addresses) so it lines up with
// the butterfly outputs, steers each BU output to the bank/port it was read from,
// registers the write strobe/data, and counts write beats per NTT stage.
module bu_writeback_router #(
    parameter int DATA_WIDTH  = 13,
    parameter int ADDR_WIDTH  = 5,
    parameter int BU_LAT      = 3,
    parameter int STAGE_BEATS = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              rd_valid_i,
    input  logic [7:0]                        len_i,
    input  logic                              is_NTT_i,
    input  logic [ADDR_WIDTH-1:0]             rd_addr_a_i,
    input  logic [ADDR_WIDTH-1:0]             rd_addr_b_i,
    input  logic [8*(DATA_WIDTH-1)-1:0]       bu_a_ntt_i,
    input  logic [8*(DATA_WIDTH-1)-1:0]       bu_b_ntt_i,
    input  logic [8*(DATA_WIDTH-1)-1:0]       bu_a_intt_i,
    input  logic [8*(DATA_WIDTH-1)-1:0]       bu_b_intt_i,
    output logic                              wr_en_o,
    output logic [ADDR_WIDTH-1:0]             wr_addr_a_o,
    output logic [ADDR_WIDTH-1:0]             wr_addr_b_o,
    output logic [8*(DATA_WIDTH-1)-1:0]       wr_data_a_o,
    output logic [8*(DATA_WIDTH-1)-1:0]       wr_data_b_o,
    output logic [$clog2(STAGE_BEATS)-1:0]    beat_cnt_o,
    output logic                              stage_done_o,
    output logic                              err_len_o
);

    // Stored coefficient width; the BU operand carries one extra bit.
    localparam int W     = DATA_WIDTH - 1;
    localparam int CNT_W = $clog2(STAGE_BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Control that must travel with a beat through the BU pipeline.
    typedef struct packed {
        logic                  vld;
        logic [7:0]            len;
        logic                  mode;
        logic [ADDR_WIDTH-1:0] addr_a;
        logic [ADDR_WIDTH-1:0] addr_b;
    } beat_t;

    beat_t dl_q [BU_LAT];
    beat_t dl_d [BU_LAT];
    beat_t tail;

    logic                  wr_en_q,      wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_a_q,  wr_addr_a_d;
    logic [ADDR_WIDTH-1:0] wr_addr_b_q,  wr_addr_b_d;
    logic [8*W-1:0]        wr_data_a_q,  wr_data_a_d;
    logic [8*W-1:0]        wr_data_b_q,  wr_data_b_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [1:0]            state_q,      state_d;
    logic                  done_q,       done_d;
    logic                  err_q,        err_d;

    logic [2:0]            len_info;
    logic                  len_legal;
    logic [1:0]            len_cls;
    logic                  counted;
    logic [W-1:0]          route_a [8];
    logic [W-1:0]          route_b [8];

    // Classify a stage len: {legal, class}. Class 3 covers every len from 16 down to 2,
    // which all share the same read mapping.
    function automatic logic [2:0] decode_len(input logic [7:0] len);
        case (len)
            8'd128:                   decode_len = 3'b100;
            8'd64:                    decode_len = 3'b101;
            8'd32:                    decode_len = 3'b110;
            8'd16, 8'd8, 8'd4, 8'd2:  decode_len = 3'b111;
            default:                  decode_len = 3'b000;
        endcase
    endfunction

    // Destination of one BU output as {port_b, bank}. The A output lands on the even bank
    // of a pair and the B output on the odd one, except for the two short-len BUs that
    // write the same bank on both ports.
    function automatic logic [3:0] route_dest(input logic [1:0] cls, input logic [2:0] j,
                                              input logic is_b);
        logic       port;
        logic [2:0] base;
        logic [2:0] bank;
        case (cls)
            2'd0:    begin port = j[2]; base = {j[1:0], 1'b0};       end
            2'd1:    begin port = j[1]; base = {j[2], j[0], 1'b0};   end
            default: begin port = j[0]; base = {j[2:1], 1'b0};       end
        endcase
        bank = base | {2'b00, is_b};
        if (cls == 2'd3 && j[2:1] == 2'b00) begin
            port = is_b;
            bank = {2'b00, j[0]};
        end
        route_dest = {port, bank};
    endfunction

    assign tail      = dl_q[BU_LAT-1];
    assign len_info  = decode_len(tail.len);
    assign len_legal = len_info[2];
    assign len_cls   = len_info[1:0];
    assign counted   = tail.vld & len_legal;

    // Shift the beat control one stage per cycle; the tail coincides with the BU outputs.
    always_comb begin
        dl_d[0] = '{vld: rd_valid_i, len: len_i, mode: is_NTT_i,
                    addr_a: rd_addr_a_i, addr_b: rd_addr_b_i};
        for (int k = 1; k < BU_LAT; k++) begin
            dl_d[k] = dl_q[k-1];
        end
    end

    // Select NTT/iNTT outputs and scatter them to their bank/port slots.
    always_comb begin
        logic [3:0]   dst;
        logic [W-1:0] a_src;
        logic [W-1:0] b_src;
        for (int k = 0; k < 8; k++) begin
            route_a[k] = '0;
            route_b[k] = '0;
        end
        for (int j = 0; j < 8; j++) begin
            a_src = tail.mode ? bu_a_ntt_i[j*W +: W] : bu_a_intt_i[j*W +: W];
            b_src = tail.mode ? bu_b_ntt_i[j*W +: W] : bu_b_intt_i[j*W +: W];
            dst = route_dest(len_cls, 3'(j), 1'b0);
            if (dst[3]) route_b[dst[2:0]] = a_src;
            else        route_a[dst[2:0]] = a_src;
            dst = route_dest(len_cls, 3'(j), 1'b1);
            if (dst[3]) route_b[dst[2:0]] = b_src;
            else        route_a[dst[2:0]] = b_src;
        end
    end

    // Next output-register values: load on a legal beat, otherwise hold; latch len errors.
    always_comb begin
        wr_en_d     = counted;
        wr_addr_a_d = wr_addr_a_q;
        wr_addr_b_d = wr_addr_b_q;
        wr_data_a_d = wr_data_a_q;
        wr_data_b_d = wr_data_b_q;
        if (counted) begin
            wr_addr_a_d = tail.addr_a;
            wr_addr_b_d = tail.addr_b;
            for (int k = 0; k < 8; k++) begin
                wr_data_a_d[k*W +: W] = route_a[k];
                wr_data_b_d[k*W +: W] = route_b[k];
            end
        end
        err_d = err_q | (tail.vld & ~len_legal);
    end

    // Stage FSM: count legal write beats and pulse done alongside the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (counted) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ONE;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (counted) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Delay-line registers; reset drops any beats still in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < BU_LAT; k++) begin
                dl_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < BU_LAT; k++) begin
                dl_q[k] <= dl_d[k];
            end
        end
    end

    // Output, counter and FSM registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_en_q     <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
            wr_data_a_q <= '0;
            wr_data_b_q <= '0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_addr_a_q <= wr_addr_a_d;
            wr_addr_b_q <= wr_addr_b_d;
            wr_data_a_q <= wr_data_a_d;
            wr_data_b_q <= wr_data_b_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_a_o  = wr_addr_a_q;
    assign wr_addr_b_o  = wr_addr_b_q;
    assign wr_data_a_o  = wr_data_a_q;
    assign wr_data_b_o  = wr_data_b_q;
    assign beat_cnt_o   = cnt_q;
    assign stage_done_o = done_q;
    assign err_len_o    = err_q;

endmodule
